// File: rtl/izh_spike_monitor_if.sv
// Byte stream from the spike monitor toward the host-side I/O.
// A byte moves when out_valid && out_ready.
interface izh_spike_monitor_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/izh_spike_monitor.sv
// Windowed activity readout for the Izhikevich neuron.
// Each window produces one 5-byte frame: header, spike count, last ISI (hi, lo), peak membrane value.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in flight; a window close loads the snapshot
// SEND  | streaming snapshot bytes 0..4; a window close is dropped
module izh_spike_monitor #(
  parameter int unsigned WINDOW_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  spike_i,
  input  logic [7:0]            v_i,
  output logic                  overrun_o,
  izh_spike_monitor_if.master   out_if
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        snap_load, ovr_set;

  logic        spike_q, seen;
  logic [15:0] wrem;
  logic [7:0]  scnt, vmax;
  logic [15:0] isi_cnt, last_isi;
  logic [7:0]  snap_cnt, snap_vmax;
  logic [15:0] snap_isi;

  logic        spk_edge, win_close;
  logic [7:0]  scnt_next, vmax_next, next_byte;
  logic [15:0] last_isi_next;

  // Window timing runs as a down-counter; remaining==0 is the last cycle of the window.
  assign spk_edge      = spike_i & ~spike_q & en_i;
  assign win_close     = en_i & (wrem == 16'd0);
  assign scnt_next     = (spk_edge && scnt != 8'hFF) ? scnt + 8'd1 : scnt;
  assign vmax_next     = (v_i > vmax) ? v_i : vmax;
  assign last_isi_next = (spk_edge && seen) ? isi_cnt : last_isi;

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = (state_q == SEND);

  // Measurement datapath: edge detect, window timer, accumulators and snapshot capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q   <= 1'b0;
      seen      <= 1'b0;
      wrem      <= WIN_LAST;
      scnt      <= 8'h00;
      vmax      <= 8'h00;
      isi_cnt   <= 16'h0000;
      last_isi  <= 16'h0000;
      snap_cnt  <= 8'h00;
      snap_vmax <= 8'h00;
      snap_isi  <= 16'h0000;
    end else begin
      spike_q <= spike_i;
      if (en_i) begin
        wrem     <= win_close ? WIN_LAST : wrem - 16'd1;
        scnt     <= win_close ? 8'h00 : scnt_next;
        vmax     <= win_close ? 8'h00 : vmax_next;
        last_isi <= last_isi_next;
        if (spk_edge) begin
          isi_cnt <= 16'd1;
          seen    <= 1'b1;
        end else if (isi_cnt != 16'hFFFF) begin
          isi_cnt <= isi_cnt + 16'd1;
        end
      end
      if (snap_load) begin
        snap_cnt  <= scnt_next;
        snap_vmax <= vmax_next;
        snap_isi  <= last_isi_next;
      end
    end
  end

  // Frame FSM state, byte index, registered output byte and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      data_q    <= 8'h00;
      overrun_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      overrun_o <= overrun_o | ovr_set;
    end
  end

  // Next-state logic; byte 0 is built directly from the live overrun flag at snapshot time.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    snap_load = 1'b0;
    ovr_set   = 1'b0;
    next_byte = 8'h00;
    case (idx_q)
      3'd0:    next_byte = snap_cnt;
      3'd1:    next_byte = snap_isi[15:8];
      3'd2:    next_byte = snap_isi[7:0];
      3'd3:    next_byte = snap_vmax;
      default: next_byte = 8'h00;
    endcase
    case (state_q)
      IDLE: begin
        if (win_close) begin
          snap_load = 1'b1;
          state_d   = SEND;
          idx_d     = 3'd0;
          data_d    = 8'hA4 | {7'b0, overrun_o};
        end
      end
      SEND: begin
        if (win_close) ovr_set = 1'b1;
        if (out_if.out_ready) begin
          if (idx_q == 3'd4) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            data_d  = 8'h00;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = next_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/izh_spike_monitor.md
# izh_spike_monitor

Readout block for the Izhikevich neuron system: it observes the neuron's spike output and 8-bit membrane value and measures activity over fixed windows. Per window it records the spike count, the latest inter-spike interval and the peak membrane value. It streams each window's result as a 5-byte frame over a valid/ready byte interface toward the host-side I/O. It is the consuming end of the neuron's output path; the neuron core drives the stimulus side.

## Interface
- WINDOW_CYCLES, 1000: measurement window length in clock cycles. Legal range 8 to 65535.
- clk  in  1  system clock; every input is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  measurement enable. When low, window counter, ISI counter and accumulators hold.
- spike_i  in  1  neuron spike level; each rising edge is one spike.
- v_i  in  8  membrane value, unsigned.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- overrun_o  out  1  sticky flag: a window result was dropped. Cleared only by reset.

## Operation
- Edge detect: spike_q <= spike_i every cycle (including when en_i=0). edge = spike_i & ~spike_q & en_i.
- Window counter wcnt runs 0..WINDOW_CYCLES-1 and wraps; it advances only when en_i=1. The window closes in the cycle where en_i=1 and wcnt==WINDOW_CYCLES-1.
- Spike count scnt (8 bit):
  - +1 on each edge, saturating at 255.
  - On window close, the snapshot includes that cycle's edge, then scnt clears to 0.
- Peak vmax (8 bit):
  - When en_i=1, vmax <= max(vmax, v_i).
  - The snapshot includes the closing cycle's v_i; vmax then clears to 0.
- ISI:
  - isi_cnt (16 bit) increments each enabled cycle, saturating at 0xFFFF. It is set to 1 on an edge.
  - On an edge with seen=1, last_isi <= isi_cnt. seen is set by the first edge.
  - Net effect: edges at enabled cycles t1 and t2 give last_isi = t2 - t1.
  - isi_cnt, last_isi and seen are not cleared at window boundaries.
  - The snapshot uses last_isi including an update from an edge in the closing cycle.
- Frame format, bytes 0..4: header = 0xA4 | overrun_o; count; isi[15:8]; isi[7:0]; vmax. The header reflects overrun_o as of the snapshot cycle.
- FSM:
  - IDLE: out_valid=0. On window close, load the snapshot registers and go to SEND with idx=0.
  - SEND: out_valid=1 and out_data = byte[idx]. On out_valid && out_ready: if idx==4, go to IDLE; else idx+1.
- Overrun: a window close while in SEND drops that snapshot and sets overrun_o. This includes the cycle in which byte 4 is accepted. The frame in flight is never corrupted.
- en_i=0 does not stall or abort a frame in SEND.

## Timing
- Reset values: out_data=0x00, out_valid=0, overrun_o=0. All counters, spike_q, seen, last_isi and snapshot registers are 0. FSM state is IDLE.
- Reset is asynchronous. Asserting rst_n mid-frame forces out_valid=0 immediately and discards the frame.
- out_valid rises in the cycle after the window-close cycle.
- out_data and out_valid are registered and held stable while out_valid && !out_ready.
- Throughput: one byte per cycle with out_ready held high. A frame takes 5 cycles.
- A spike level held high counts once. A one-cycle pulse counts once.
- A rising edge that occurs while en_i=0 is lost. spike_q keeps tracking, so no spurious edge appears when en_i returns high.

## Test plan
- WINDOW_CYCLES=16, out_ready=1, no spikes, v_i=0x30 constant:
  - out_valid first rises in cycle 16 after reset release.
  - Frame is A4 00 00 00 30.
  - The next frame starts 16 cycles later.
- Single-cycle spike pulses at enabled cycles 2 and 9, v_i peaking at 0x7F in cycle 5 -> frame A4 02 00 07 7F.
- Spike in the closing cycle (wcnt=15), previous spike at wcnt=3 -> count includes it and isi=0x000C. The following window reports count 0 and isi still 0x000C.
- out_ready held low for 40 cycles after the first frame starts:
  - Byte 0 is held stable throughout.
  - Windows closing meanwhile are dropped and overrun_o=1.
  - After release, the in-flight frame completes unchanged as A4 ...
  - The next frame header is 0xA5.
- 300 spike pulses in one window of WINDOW_CYCLES=1000 -> count byte 0xFF. Spikes with no edge for more than 65535 enabled cycles -> next isi=0xFFFF.
- Reset asserted during byte 2 of a frame -> out_valid=0 asynchronously. After release, the first frame appears 16 cycles later with header 0xA4.
